xcvr_init_sequencer: RTL and testbench



---
 rtl/xcvr_init_sequencer.sv | 137 +++++++++++++
 tb/tb_xcvr_init_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/xcvr_init_sequencer.sv
// Bring-up sequencer for one transceiver lane: qualifies PLL lock, steps the
// PMA/PCS resets, waits for CDR lock with bounded retries, and re-runs on lock loss.
module xcvr_init_sequencer #(
  parameter int PLL_LOCK_FILTER = 256,
  parameter int PMA_RST_CYCLES  = 64,
  parameter int CDR_TIMEOUT     = 100000,
  parameter int PCS_RST_CYCLES  = 32,
  parameter int MAX_RETRIES     = 7,
  parameter int CNT_W           = 20
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       PLL_LOCK,
  input  logic       CDR_LOCK,
  output logic       PMA_RST,
  output logic       PCS_RST,
  output logic       READY,
  output logic       FAIL,
  output logic [3:0] RETRY_CNT,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_PLL = 3'd1,
    S_PMA_RST  = 3'd2,
    S_WAIT_CDR = 3'd3,
    S_PCS_RST  = 3'd4,
    S_READY    = 3'd5,
    S_FAIL     = 3'd6
  } state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt, next_cnt;
  logic [3:0]       retry, next_retry;
  logic             pll_meta, pll_s, cdr_meta, cdr_s;

  // Two-flop synchronizers for the asynchronous lock indications.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pll_meta <= 1'b0;
      pll_s    <= 1'b0;
      cdr_meta <= 1'b0;
      cdr_s    <= 1'b0;
    end else begin
      pll_meta <= PLL_LOCK;
      pll_s    <= pll_meta;
      cdr_meta <= CDR_LOCK;
      cdr_s    <= cdr_meta;
    end
  end

  // The counter defaults to zero, so any state change reloads it; it only
  // advances while the FSM stays in a timed state (or WAIT_PLL filtering).
  always_comb begin
    next_state = state;
    next_cnt   = '0;
    next_retry = retry;
    case (state)
      S_IDLE: begin
        if (START) next_state = S_WAIT_PLL;
      end
      S_WAIT_PLL: begin
        if (pll_s) begin
          if (cnt == CNT_W'(PLL_LOCK_FILTER - 1)) next_state = S_PMA_RST;
          else next_cnt = cnt + CNT_W'(1);
        end
      end
      S_PMA_RST: begin
        if (!pll_s) next_state = S_WAIT_PLL;
        else if (cnt == CNT_W'(PMA_RST_CYCLES - 1)) next_state = S_WAIT_CDR;
        else next_cnt = cnt + CNT_W'(1);
      end
      S_WAIT_CDR: begin
        if (!pll_s) next_state = S_WAIT_PLL;
        else if (cdr_s) next_state = S_PCS_RST;
        else if (cnt == CNT_W'(CDR_TIMEOUT - 1)) begin
          if (32'(retry) < MAX_RETRIES) begin
            next_state = S_PMA_RST;
            if (retry != 4'hF) next_retry = retry + 4'd1;
          end else begin
            next_state = S_FAIL;
          end
        end else next_cnt = cnt + CNT_W'(1);
      end
      S_PCS_RST: begin
        if (!pll_s) next_state = S_WAIT_PLL;
        else if (!cdr_s) next_state = S_WAIT_CDR;
        else if (cnt == CNT_W'(PCS_RST_CYCLES - 1)) next_state = S_READY;
        else next_cnt = cnt + CNT_W'(1);
      end
      S_READY: begin
        if (!pll_s) begin
          next_state = S_WAIT_PLL;
          next_retry = 4'd0;
        end else if (!cdr_s) begin
          next_state = S_PMA_RST;
          next_retry = 4'd0;
        end
      end
      S_FAIL: next_state = S_FAIL;
      default: next_state = S_IDLE;
    endcase
    if (!START) begin
      next_state = S_IDLE;
      next_cnt   = '0;
      next_retry = 4'd0;
    end
  end

  // Outputs are decoded from next_state so they move on the same edge as STATE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      cnt     <= '0;
      retry   <= 4'd0;
      PMA_RST <= 1'b1;
      PCS_RST <= 1'b1;
      READY   <= 1'b0;
      FAIL    <= 1'b0;
    end else begin
      state   <= next_state;
      cnt     <= next_cnt;
      retry   <= next_retry;
      PMA_RST <= (next_state == S_IDLE) || (next_state == S_WAIT_PLL) ||
                 (next_state == S_PMA_RST);
      PCS_RST <= (next_state != S_READY);
      READY   <= (next_state == S_READY);
      FAIL    <= (next_state == S_FAIL);
    end
  end

  assign STATE     = state;
  assign RETRY_CNT = retry;

endmodule

// File: tb/tb_xcvr_init_sequencer.sv
// Directed bench for xcvr_init_sequencer with small timing parameters
// (F=8, P=4, CDR_TIMEOUT=50, C=3, MAX_RETRIES=2); expected edges are hand-computed.
module tb_xcvr_init_sequencer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START;
  logic       PLL_LOCK;
  logic       CDR_LOCK;
  logic       PMA_RST;
  logic       PCS_RST;
  logic       READY;
  logic       FAIL;
  logic [3:0] RETRY_CNT;
  logic [2:0] STATE;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  xcvr_init_sequencer #(
    .PLL_LOCK_FILTER(8),
    .PMA_RST_CYCLES (4),
    .CDR_TIMEOUT    (50),
    .PCS_RST_CYCLES (3),
    .MAX_RETRIES    (2),
    .CNT_W          (20)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    .PLL_LOCK (PLL_LOCK),
    .CDR_LOCK (CDR_LOCK),
    .PMA_RST  (PMA_RST),
    .PCS_RST  (PCS_RST),
    .READY    (READY),
    .FAIL     (FAIL),
    .RETRY_CNT(RETRY_CNT),
    .STATE    (STATE)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic pll, input logic cdr);
    START    = start;
    PLL_LOCK = pll;
    CDR_LOCK = cdr;
  endtask

  // Advance n rising edges and settle 1ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset held with START and both locks high.
    RST = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick(3);
    checkOutput("rst_state", 32'(STATE), 0);
    checkOutput("rst_pma", 32'(PMA_RST), 1);
    checkOutput("rst_pcs", 32'(PCS_RST), 1);
    checkOutput("rst_ready", 32'(READY), 0);
    checkOutput("rst_fail", 32'(FAIL), 0);
    checkOutput("rst_retry", 32'(RETRY_CNT), 0);

    // Edge 0 samples START; synchronizers restart from 0 after reset.
    RST = 1'b0;
    tick(1);
    checkOutput("hp_e0_state", 32'(STATE), 1);
    tick(8);
    checkOutput("hp_e8_state", 32'(STATE), 1);
    tick(1);
    checkOutput("hp_e9_state", 32'(STATE), 2);
    checkOutput("hp_e9_pma", 32'(PMA_RST), 1);
    tick(3);
    checkOutput("hp_e12_state", 32'(STATE), 2);
    tick(1);
    checkOutput("hp_e13_state", 32'(STATE), 3);
    checkOutput("hp_e13_pma", 32'(PMA_RST), 0);
    checkOutput("hp_e13_pcs", 32'(PCS_RST), 1);
    tick(1);
    checkOutput("hp_e14_state", 32'(STATE), 4);
    tick(2);
    checkOutput("hp_e16_ready", 32'(READY), 0);
    tick(1);
    checkOutput("hp_e17_state", 32'(STATE), 5);
    checkOutput("hp_e17_ready", 32'(READY), 1);
    checkOutput("hp_e17_pcs", 32'(PCS_RST), 0);

    // PLL filter: a 7-cycle lock pulse must not qualify; filter restarts.
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(3);
    checkOutput("idle_state", 32'(STATE), 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick(1);
    checkOutput("flt_enter", 32'(STATE), 1);
    tick(2);
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick(7);
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick(9);
    checkOutput("flt_still_wait", 32'(STATE), 1);
    tick(1);
    checkOutput("flt_pma_entry", 32'(STATE), 2);

    // CDR never locks: two retries 54 cycles apart, then FAIL.
    tick(4);
    checkOutput("cdr_wait_entry", 32'(STATE), 3);
    tick(49);
    checkOutput("cdr_pre_to1_state", 32'(STATE), 3);
    checkOutput("cdr_pre_to1_retry", 32'(RETRY_CNT), 0);
    tick(1);
    checkOutput("cdr_to1_state", 32'(STATE), 2);
    checkOutput("cdr_to1_retry", 32'(RETRY_CNT), 1);
    tick(54);
    checkOutput("cdr_to2_state", 32'(STATE), 2);
    checkOutput("cdr_to2_retry", 32'(RETRY_CNT), 2);
    tick(53);
    checkOutput("cdr_pre_to3_state", 32'(STATE), 3);
    checkOutput("cdr_pre_to3_fail", 32'(FAIL), 0);
    tick(1);
    checkOutput("fail_state", 32'(STATE), 6);
    checkOutput("fail_flag", 32'(FAIL), 1);
    checkOutput("fail_pma", 32'(PMA_RST), 0);
    checkOutput("fail_pcs", 32'(PCS_RST), 1);
    checkOutput("fail_retry", 32'(RETRY_CNT), 2);
    tick(5);
    checkOutput("fail_sticky", 32'(STATE), 6);

    // Abort from FAIL, then rerun with one timeout before CDR locks.
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(1);
    checkOutput("abort_fail_state", 32'(STATE), 0);
    checkOutput("abort_fail_retry", 32'(RETRY_CNT), 0);
    checkOutput("abort_fail_flag", 32'(FAIL), 0);
    checkOutput("abort_fail_pma", 32'(PMA_RST), 1);
    tick(2);
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick(1);
    checkOutput("rec_e0_state", 32'(STATE), 1);
    tick(61);
    checkOutput("rec_e61_state", 32'(STATE), 3);
    tick(1);
    checkOutput("rec_e62_state", 32'(STATE), 2);
    checkOutput("rec_e62_retry", 32'(RETRY_CNT), 1);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick(3);
    checkOutput("rec_e66_state", 32'(STATE), 3);
    tick(1);
    checkOutput("rec_e67_state", 32'(STATE), 4);
    tick(2);
    checkOutput("rec_e69_ready", 32'(READY), 0);
    tick(1);
    checkOutput("rec_e70_state", 32'(STATE), 5);
    checkOutput("rec_e70_ready", 32'(READY), 1);
    checkOutput("rec_e70_retry", 32'(RETRY_CNT), 1);

    // CDR loss while READY: back to PMA_RST three edges later, retries cleared.
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick(2);
    checkOutput("cdrloss_hold_ready", 32'(READY), 1);
    tick(1);
    checkOutput("cdrloss_state", 32'(STATE), 2);
    checkOutput("cdrloss_ready", 32'(READY), 0);
    checkOutput("cdrloss_pma", 32'(PMA_RST), 1);
    checkOutput("cdrloss_retry", 32'(RETRY_CNT), 0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick(8);
    checkOutput("cdrloss_relock", 32'(READY), 1);

    // PLL loss while READY: back to WAIT_PLL.
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick(2);
    checkOutput("pllloss_hold_ready", 32'(READY), 1);
    tick(1);
    checkOutput("pllloss_state", 32'(STATE), 1);
    checkOutput("pllloss_ready", 32'(READY), 0);
    checkOutput("pllloss_pma", 32'(PMA_RST), 1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick(18);
    checkOutput("pllloss_relock_state", 32'(STATE), 5);

    // Abort mid WAIT_CDR after one timeout.
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick(3);
    checkOutput("abort_pma_state", 32'(STATE), 2);
    tick(4);
    checkOutput("abort_wcdr_state", 32'(STATE), 3);
    tick(54);
    checkOutput("abort_wcdr2_state", 32'(STATE), 3);
    checkOutput("abort_wcdr2_retry", 32'(RETRY_CNT), 1);
    tick(4);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(1);
    checkOutput("abort_cdr_state", 32'(STATE), 0);
    checkOutput("abort_cdr_retry", 32'(RETRY_CNT), 0);
    checkOutput("abort_cdr_pcs", 32'(PCS_RST), 1);

    // Simultaneous PLL and CDR loss during PCS_RST: PLL rule wins.
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick(1);
    checkOutput("sim_e0_state", 32'(STATE), 1);
    tick(13);
    checkOutput("sim_e13_state", 32'(STATE), 4);
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick(2);
    checkOutput("sim_e15_state", 32'(STATE), 4);
    tick(1);
    checkOutput("sim_e16_state", 32'(STATE), 1);
    checkOutput("sim_e16_pma", 32'(PMA_RST), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
